// File: rtl/round_ctrl.sv
// Purpose : game-round sequencer between the BCD countdown timer and the display/game logic.
// Latency : every output is registered; it reflects the inputs sampled on the previous Clk edge.
// Backpressure: none. start is a level, hit is a single-cycle pulse, and both are consumed as they arrive.
//
// Ports:
//   Clk, Reset        - clock; synchronous active-high reset
//   start             - level; arms a new round from IDLE or DONE
//   hit               - single-cycle score pulse; counted only in PLAY
//   time_left[7:0]    - BCD seconds remaining from the timer
//   time_up           - timer expiry flag
//   timer_reset       - drives the timer's Reset; held high in IDLE and READY
//   pre_count[3:0]    - pre-round "3-2-1" digit; 0 outside READY
//   state[1:0]        - IDLE=0, READY=1, PLAY=2, DONE=3
//   score[11:0]       - 3-digit BCD score, saturating at 999
//   low_time          - registered low-time warning
//   round_done        - one-cycle pulse on DONE entry
//   high_score[11:0]  - best BCD score since Reset
//   new_record        - one-cycle pulse when high_score is updated
//
// Optional feature: define ROUND_CTRL_HISCORE_EN to build the high-score
// register and its compare. When the macro is undefined, high_score reads 0
// and new_record reads 0, and both ports remain present.

module round_ctrl #(
   parameter int          TICKS_PER_SEC = 50000000,
   parameter int          PRE_COUNT     = 3,
   parameter logic [7:0]  WARN_BCD      = 8'h10,
   parameter logic [11:0] HIT_POINTS    = 12'h005
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic        hit,
   input  logic [7:0]  time_left,
   input  logic        time_up,
   output logic        timer_reset,
   output logic [3:0]  pre_count,
   output logic [1:0]  state,
   output logic [11:0] score,
   output logic        low_time,
   output logic        round_done,
   output logic [11:0] high_score,
   output logic        new_record
);

   localparam int             TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0]  TICK_MAX = TW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]     PRE_INIT = 4'(PRE_COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READY = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } st_t;

   st_t            st_q, st_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [3:0]     pre_d;
   logic [11:0]    score_d;
   logic           trst_d;
   logic           low_d;
   logic           done_d;
   logic [12:0]    sum;
   logic [11:0]    score_inc;

   // Three-digit BCD add. Bit 12 is the carry out of the hundreds digit,
   // which means the true sum exceeded 999.
   function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
      logic [4:0]  d;
      logic        c;
      logic [11:0] r;
      c = 1'b0;
      r = 12'h000;
      for (int i = 0; i < 3; i++) begin
         d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
         if (d > 5'd9) begin
            d = d + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = d[3:0];
      end
      return {c, r};
   endfunction

   always_comb begin
      sum       = bcd_add(score, HIT_POINTS);
      score_inc = sum[12] ? 12'h999 : sum[11:0];
   end

   // Next-state and next-output logic
   always_comb begin
      st_d    = st_q;
      tick_d  = tick_q;
      pre_d   = pre_count;
      score_d = score;
      done_d  = 1'b0;

      case (st_q)
         S_IDLE, S_DONE: begin
            // The score clear and the timer re-reset both happen on the way into READY.
            if (start) begin
               st_d    = S_READY;
               pre_d   = PRE_INIT;
               tick_d  = '0;
               score_d = 12'h000;
            end
         end
         S_READY: begin
            if (tick_q == TICK_MAX) begin
               tick_d = '0;
               pre_d  = pre_count - 4'd1;
               if (pre_count == 4'd1) begin
                  st_d = S_PLAY;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         S_PLAY: begin
            // A hit in the same cycle as time_up still counts toward the final score.
            if (hit) begin
               score_d = score_inc;
            end
            if (time_up) begin
               st_d   = S_DONE;
               done_d = 1'b1;
            end
         end
         default: st_d = S_IDLE;
      endcase

      // The timer is released on the PLAY entry edge, so it still reads 60 there.
      trst_d = (st_d == S_IDLE) || (st_d == S_READY);
      low_d  = (st_q == S_PLAY) && (time_left <= WARN_BCD) && (time_left != 8'h00);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         st_q        <= S_IDLE;
         tick_q      <= '0;
         pre_count   <= 4'd0;
         score       <= 12'h000;
         timer_reset <= 1'b1;
         low_time    <= 1'b0;
         round_done  <= 1'b0;
      end else begin
         st_q        <= st_d;
         tick_q      <= tick_d;
         pre_count   <= pre_d;
         score       <= score_d;
         timer_reset <= trst_d;
         low_time    <= low_d;
         round_done  <= done_d;
      end
   end

   assign state = st_q;

`ifdef ROUND_CTRL_HISCORE_EN
   logic rec_d;

   // Compare against the final score, including a hit taken on the last cycle.
   // Plain unsigned compare orders valid BCD values correctly.
   always_comb begin
      rec_d = done_d && (score_d > high_score);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         high_score <= 12'h000;
         new_record <= 1'b0;
      end else begin
         new_record <= rec_d;
         if (rec_d) begin
            high_score <= score_d;
         end
      end
   end
`else
   assign high_score = 12'h000;
   assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
module tb_round_ctrl;

   localparam int         T    = 4;
   localparam int         PRE  = 3;
   localparam logic [7:0] WARN = 8'h10;

   logic        Clk = 1'b0;
   logic        Reset, start, hit, time_up;
   logic [7:0]  time_left;
   logic        timer_reset, low_time, round_done, new_record;
   logic [3:0]  pre_count;
   logic [1:0]  state;
   logic [11:0] score, high_score;

   int total = 0;
   int bad   = 0;

   // Reference model: round phase, cycles spent in READY, and decimal scores.
   int m_st, m_el, m_sc, m_hi;
   bit m_low, m_done, m_rec;

   round_ctrl #(
      .TICKS_PER_SEC(T),
      .PRE_COUNT(PRE),
      .WARN_BCD(WARN),
      .HIT_POINTS(12'h005)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .start(start),
      .hit(hit),
      .time_left(time_left),
      .time_up(time_up),
      .timer_reset(timer_reset),
      .pre_count(pre_count),
      .state(state),
      .score(score),
      .low_time(low_time),
      .round_done(round_done),
      .high_score(high_score),
      .new_record(new_record)
   );

   always #5 Clk = ~Clk;

   function automatic logic [11:0] d2b(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int b2d(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_next();
      int tl;
      tl = b2d(time_left);
      if (Reset) begin
         m_st = 0; m_el = 0; m_sc = 0; m_hi = 0;
         m_low = 0; m_done = 0; m_rec = 0;
      end else begin
         m_low  = (m_st == 2) && (tl <= b2d(WARN)) && (tl != 0);
         m_done = 0;
         m_rec  = 0;
         case (m_st)
            0, 3: if (start) begin m_st = 1; m_el = 0; m_sc = 0; end
            1: begin
               m_el++;
               if (m_el == PRE * T) m_st = 2;
            end
            2: begin
               if (hit) m_sc = (m_sc + 5 > 999) ? 999 : m_sc + 5;
               if (time_up) begin
                  m_st = 3;
                  m_done = 1;
                  if (m_sc > m_hi) begin m_hi = m_sc; m_rec = 1; end
               end
            end
            default: m_st = 0;
         endcase
      end
   endtask

   // Advance one clock and compare every output against the model.
   task automatic step();
      model_next();
      @(posedge Clk);
      #1;
      chk("state", {10'b0, state}, 12'(m_st));
      chk("timer_reset", {11'b0, timer_reset}, {11'b0, (m_st <= 1)});
      chk("pre_count", {8'b0, pre_count}, (m_st == 1) ? 12'(PRE - m_el / T) : 12'h000);
      chk("score", score, d2b(m_sc));
      chk("low_time", {11'b0, low_time}, {11'b0, m_low});
      chk("round_done", {11'b0, round_done}, {11'b0, m_done});
`ifdef ROUND_CTRL_HISCORE_EN
      chk("high_score", high_score, d2b(m_hi));
      chk("new_record", {11'b0, new_record}, {11'b0, m_rec});
`else
      chk("high_score", high_score, 12'h000);
      chk("new_record", {11'b0, new_record}, 12'h000);
`endif
   endtask

   task automatic start_round();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (PRE * T) step();
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; hit = 1'b0; time_up = 1'b0; time_left = 8'h60;
      m_st = 0; m_el = 0; m_sc = 0; m_hi = 0; m_low = 0; m_done = 0; m_rec = 0;
      step();
      step();
      chk("rst_state", {10'b0, state}, 12'h000);
      chk("rst_trst", {11'b0, timer_reset}, 12'h001);
      chk("rst_score", score, 12'h000);
      Reset = 1'b0;
      step();

      // Pre-round countdown: 3,2,1 for T cycles each, PLAY on the 13th edge
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ready_entry", {10'b0, state}, 12'h001);
      chk("pre3", {8'b0, pre_count}, 12'h003);
      repeat (4) step();
      chk("pre2", {8'b0, pre_count}, 12'h002);
      repeat (7) step();
      chk("pre1_last", {8'b0, pre_count}, 12'h001);
      step();
      chk("play_entry", {10'b0, state}, 12'h002);
      chk("trst_fall", {11'b0, timer_reset}, 12'h000);

      // Three hits
      hit = 1'b1;
      repeat (3) step();
      hit = 1'b0;
      chk("score_015", score, 12'h015);

      // Low-time threshold
      time_left = 8'h11; step();
      chk("low_11", {11'b0, low_time}, 12'h000);
      time_left = 8'h10; step();
      chk("low_10", {11'b0, low_time}, 12'h001);
      time_left = 8'h00; step();
      chk("low_00", {11'b0, low_time}, 12'h000);
      time_left = 8'h60; step();

      // Hit coinciding with time_up
      hit = 1'b1; step();
      chk("score_020", score, 12'h020);
      time_up = 1'b1; step();
      hit = 1'b0; time_up = 1'b0;
      chk("score_025", score, 12'h025);
      chk("done_state", {10'b0, state}, 12'h003);
      chk("round_done_hi", {11'b0, round_done}, 12'h001);
`ifdef ROUND_CTRL_HISCORE_EN
      chk("hs_025", high_score, 12'h025);
      chk("rec_pulse", {11'b0, new_record}, 12'h001);
`else
      chk("hs_off", high_score, 12'h000);
`endif
      hit = 1'b1; step(); hit = 1'b0;
      chk("round_done_lo", {11'b0, round_done}, 12'h000);
      chk("done_hit_ignored", score, 12'h025);

      // Second round with a lower score
      start_round();
      hit = 1'b1; repeat (2) step(); hit = 1'b0;
      chk("score_010", score, 12'h010);
      time_up = 1'b1; step(); time_up = 1'b0;
      chk("no_rec", {11'b0, new_record}, 12'h000);
`ifdef ROUND_CTRL_HISCORE_EN
      chk("hs_kept", high_score, 12'h025);
`else
      chk("hs_off2", high_score, 12'h000);
`endif
      step();

      // Saturation
      start_round();
      hit = 1'b1;
      repeat (199) step();
      chk("score_995", score, 12'h995);
      step();
      chk("score_sat", score, 12'h999);
      step();
      chk("score_sat_hold", score, 12'h999);
      hit = 1'b0;

      // Reset in the middle of PLAY
      Reset = 1'b1; step(); Reset = 1'b0;
      start_round();
      hit = 1'b1; repeat (8) step(); hit = 1'b0;
      time_left = 8'h05; step();
      chk("score_040", score, 12'h040);
      chk("low_05", {11'b0, low_time}, 12'h001);
      Reset = 1'b1; step(); Reset = 1'b0;
      chk("mid_rst_state", {10'b0, state}, 12'h000);
      chk("mid_rst_score", score, 12'h000);
      chk("mid_rst_trst", {11'b0, timer_reset}, 12'h001);
      chk("mid_rst_low", {11'b0, low_time}, 12'h000);
      time_left = 8'h60;
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         Reset     = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 7) == 0);
         hit       = ($urandom_range(0, 2) == 0);
         time_up   = ($urandom_range(0, 39) == 0);
         time_left = 8'(d2b($urandom_range(0, 60)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
